// File: rtl/key_cmd_pkg.sv
// Shared definitions for the key command scheduler and the board debounce logic.
// Holds the scheduler state encoding, requester bounds and board-clock timing.
package key_cmd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  localparam int KEY_NUM_MIN = 2;
  localparam int KEY_NUM_MAX = 16;

  localparam int CLK_FREQ_HZ = 25_000_000;
  localparam int TIMEOUT_MS  = 1000;

  function automatic int cyc_from_ms(input int ms);
    return (CLK_FREQ_HZ / 1000) * ms;
  endfunction

  // One second of board clock; the debounce instances derive their window from the same clock.
  localparam int DEFAULT_TIMEOUT_CYC = cyc_from_ms(TIMEOUT_MS);

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first set request at or above ptr,
// wrapping from KEY_NUM-1 back to 0.
module rr_arbiter #(
  parameter int KEY_NUM = 4,
  parameter int CODE_W  = $clog2(KEY_NUM)
) (
  input  logic [KEY_NUM-1:0] req,
  input  logic [CODE_W-1:0]  ptr,
  output logic [CODE_W-1:0]  gnt_idx,
  output logic               gnt_vld
);

  logic [CODE_W-1:0] idx;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    gnt_idx = '0;
    gnt_vld = 1'b0;
    idx     = '0;
    // Walk from the farthest offset down so the nearest requester is written last and wins.
    for (int k = KEY_NUM - 1; k >= 0; k--) begin
      idx = CODE_W'((int'(ptr) + k) % KEY_NUM);
      if (req[idx]) begin
        gnt_idx = idx;
        gnt_vld = 1'b1;
      end
    end
  end

endmodule

// File: rtl/key_cmd_sched.sv
// Latches debounced key presses as pending requests and issues them round-robin,
// one at a time, to the DDR3 traffic engine over valid/ready, waiting on cmd_done.
module key_cmd_sched
  import key_cmd_pkg::*;
#(
  parameter int KEY_NUM     = 4,
  parameter int TIMEOUT_CYC = DEFAULT_TIMEOUT_CYC,
  parameter int CODE_W      = $clog2(KEY_NUM)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [KEY_NUM-1:0] key_pulse,
  output logic               cmd_valid,
  input  logic               cmd_ready,
  output logic [CODE_W-1:0]  cmd_code,
  input  logic               cmd_done,
  output logic               busy,
  output logic [KEY_NUM-1:0] pend,
  output logic               ovf_err,
  output logic               tmo_err,
  input  logic               err_clr
);

  localparam int CNT_W = $clog2(TIMEOUT_CYC);

  state_t              state_q, state_d;
  logic [CODE_W-1:0]   rr_ptr;
  logic [CODE_W-1:0]   gnt_idx;
  logic                gnt_vld;
  logic [CNT_W-1:0]    tmo_cnt;
  logic                grant, handshake, tmo_evt;
  logic [KEY_NUM-1:0]  gnt_mask, drop;

  rr_arbiter #(
    .KEY_NUM (KEY_NUM),
    .CODE_W  (CODE_W)
  ) u_arb (
    .req     (pend),
    .ptr     (rr_ptr),
    .gnt_idx (gnt_idx),
    .gnt_vld (gnt_vld)
  );

  always_comb begin
    state_d   = state_q;
    grant     = 1'b0;
    handshake = 1'b0;
    tmo_evt   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (gnt_vld) begin
          grant   = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        // cmd_valid is always high here; cmd_done is deliberately ignored.
        if (cmd_ready) begin
          handshake = 1'b1;
          state_d   = WAIT;
        end
      end
      WAIT: begin
        if (cmd_done) begin
          state_d = IDLE;
        end else if (tmo_cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
          tmo_evt = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // A press on a still-pending key is lost, unless that key is being granted right now.
  always_comb begin
    gnt_mask = '0;
    if (grant) gnt_mask[gnt_idx] = 1'b1;
    drop = key_pulse & pend & ~gnt_mask;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      busy    <= 1'b0;
    end else begin
      state_q <= state_d;
      busy    <= (state_d != IDLE);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend      <= '0;
      rr_ptr    <= '0;
      cmd_code  <= '0;
      cmd_valid <= 1'b0;
      tmo_cnt   <= '0;
      ovf_err   <= 1'b0;
      tmo_err   <= 1'b0;
    end else begin
      pend <= (pend & ~gnt_mask) | key_pulse;

      if (grant) begin
        cmd_code <= gnt_idx;
        rr_ptr   <= (gnt_idx == CODE_W'(KEY_NUM - 1)) ? '0 : gnt_idx + CODE_W'(1);
      end

      if (grant)          cmd_valid <= 1'b1;
      else if (handshake) cmd_valid <= 1'b0;

      if (handshake)            tmo_cnt <= '0;
      else if (state_q == WAIT) tmo_cnt <= tmo_cnt + CNT_W'(1);

      // Set events take priority over a simultaneous clear.
      if (|drop)        ovf_err <= 1'b1;
      else if (err_clr) ovf_err <= 1'b0;

      if (tmo_evt)      tmo_err <= 1'b1;
      else if (err_clr) tmo_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_key_cmd_sched.sv
// Directed self-checking bench for key_cmd_sched (KEY_NUM=4, TIMEOUT_CYC=8).
module tb_key_cmd_sched;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] key_pulse;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_code;
  logic       cmd_done;
  logic       busy;
  logic [3:0] pend;
  logic       ovf_err;
  logic       tmo_err;
  logic       err_clr;

  int checks = 0;
  int errors = 0;

  key_cmd_sched #(
    .KEY_NUM     (4),
    .TIMEOUT_CYC (8)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .key_pulse (key_pulse),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_code  (cmd_code),
    .cmd_done  (cmd_done),
    .busy      (busy),
    .pend      (pend),
    .ovf_err   (ovf_err),
    .tmo_err   (tmo_err),
    .err_clr   (err_clr)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic v, input logic [1:0] code,
                           input logic b, input logic [3:0] p, input logic o, input logic t);
    check({tag, "_valid"}, cmd_valid, v);
    check({tag, "_code"},  cmd_code,  code);
    check({tag, "_busy"},  busy,      b);
    check({tag, "_pend"},  pend,      p);
    check({tag, "_ovf"},   ovf_err,   o);
    check({tag, "_tmo"},   tmo_err,   t);
  endtask

  // Wait (bounded) for an offer, check its code, handshake, then pulse done dly cycles later.
  task automatic serve(input string tag, input logic [1:0] exp_code, input int dly);
    int n = 0;
    while (!cmd_valid && n < 20) begin
      tick();
      n++;
    end
    check({tag, "_valid"}, cmd_valid, 1'b1);
    check({tag, "_code"},  cmd_code,  exp_code);
    tick();
    check({tag, "_hs"}, cmd_valid, 1'b0);
    repeat (dly - 1) tick();
    cmd_done = 1'b1;
    tick();
    cmd_done = 1'b0;
    check({tag, "_idle"}, busy, 1'b0);
  endtask

  // One backpressured cycle with optional side inputs; the offer must not move.
  task automatic bp(input string tag, input logic [3:0] p, input logic c, input logic d);
    key_pulse = p;
    err_clr   = c;
    cmd_done  = d;
    tick();
    key_pulse = '0;
    err_clr   = 1'b0;
    cmd_done  = 1'b0;
    check({tag, "_valid"}, cmd_valid, 1'b1);
    check({tag, "_code"},  cmd_code,  2'd2);
  endtask

  initial begin
    rst_n     = 1'b0;
    key_pulse = '0;
    cmd_ready = 1'b1;
    cmd_done  = 1'b0;
    err_clr   = 1'b0;
    repeat (2) tick();
    check_all("reset", 1'b0, 2'd0, 1'b0, 4'b0000, 1'b0, 1'b0);
    rst_n = 1'b1;
    tick();

    // Single press of key 2, done 5 cycles after the handshake.
    key_pulse = 4'b0100;
    tick();
    key_pulse = '0;
    check("a_pend", pend, 4'b0100);
    check("a_novalid", cmd_valid, 1'b0);
    tick();
    check_all("a_grant", 1'b1, 2'd2, 1'b1, 4'b0000, 1'b0, 1'b0);
    tick();
    check("a_hs_valid", cmd_valid, 1'b0);
    check("a_hs_busy", busy, 1'b1);
    repeat (4) begin
      tick();
      check("a_wait_busy", busy, 1'b1);
    end
    cmd_done = 1'b1;
    tick();
    cmd_done = 1'b0;
    check_all("a_done", 1'b0, 2'd2, 1'b0, 4'b0000, 1'b0, 1'b0);

    // Key 3 brings rr_ptr back to 0.
    key_pulse = 4'b1000;
    tick();
    key_pulse = '0;
    serve("b", 2'd3, 2);

    // Simultaneous presses from rr_ptr=0: order 0, 1, 3.
    key_pulse = 4'b1011;
    tick();
    key_pulse = '0;
    check("c_pend", pend, 4'b1011);
    serve("c0", 2'd0, 2);
    check("c_pend1", pend, 4'b1010);
    serve("c1", 2'd1, 3);
    check("c_pend2", pend, 4'b1000);
    serve("c3", 2'd3, 1);
    check("c_pend3", pend, 4'b0000);

    // rr_ptr is 0 again: keys 1 and 2 pending must start with 1.
    key_pulse = 4'b0110;
    tick();
    key_pulse = '0;
    serve("d1", 2'd1, 2);
    serve("d2", 2'd2, 2);

    // Press on the key being granted in the same cycle: fresh request, no overflow.
    key_pulse = 4'b0001;
    tick();
    tick();
    key_pulse = '0;
    check("e_pend", pend, 4'b0001);
    check("e_ovf", ovf_err, 1'b0);
    check("e_valid", cmd_valid, 1'b1);
    serve("e0", 2'd0, 2);
    serve("e0b", 2'd0, 2);
    check("e_pend_end", pend, 4'b0000);

    // Backpressure with drops, ignored done and clear/set collision (rr_ptr=1).
    cmd_ready = 1'b0;
    key_pulse = 4'b0100;
    tick();
    key_pulse = '0;
    tick();
    check("f_valid", cmd_valid, 1'b1);
    check("f_code", cmd_code, 2'd2);
    bp("f1", 4'b0000, 1'b0, 1'b0);
    bp("f2", 4'b0010, 1'b0, 1'b0);
    check("f_pend", pend, 4'b0010);
    check("f_ovf0", ovf_err, 1'b0);
    bp("f3", 4'b0000, 1'b0, 1'b0);
    bp("f4", 4'b0010, 1'b0, 1'b0);
    check("f_ovf_set", ovf_err, 1'b1);
    bp("f5", 4'b0000, 1'b0, 1'b1);
    check("f_done_ignored", busy, 1'b1);
    bp("f6", 4'b0010, 1'b1, 1'b0);
    check("f_ovf_setwins", ovf_err, 1'b1);
    bp("f7", 4'b0000, 1'b1, 1'b0);
    check("f_ovf_clr", ovf_err, 1'b0);
    bp("f8", 4'b0000, 1'b0, 1'b0);
    bp("f9", 4'b0000, 1'b0, 1'b0);
    bp("f10", 4'b0000, 1'b0, 1'b0);
    cmd_ready = 1'b1;
    tick();
    check("f_hs_valid", cmd_valid, 1'b0);
    check("f_hs_busy", busy, 1'b1);
    repeat (2) tick();
    check("f_single_hs", cmd_valid, 1'b0);
    cmd_done = 1'b1;
    tick();
    cmd_done = 1'b0;
    check("f_idle", busy, 1'b0);
    check("f_pend_left", pend, 4'b0010);
    serve("f_k1", 2'd1, 2);

    // Timeout with keys 0 and 3 pending (rr_ptr=2): 3 times out, then 0 is granted.
    key_pulse = 4'b1001;
    tick();
    key_pulse = '0;
    tick();
    check("g_code", cmd_code, 2'd3);
    tick();
    repeat (7) tick();
    check("g_tmo_early", tmo_err, 1'b0);
    check("g_busy_early", busy, 1'b1);
    tick();
    check("g_tmo", tmo_err, 1'b1);
    check("g_idle", busy, 1'b0);
    tick();
    check("g_next_valid", cmd_valid, 1'b1);
    check("g_next_code", cmd_code, 2'd0);

    // Done arrives on the timeout cycle: done wins.
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("h_tmo_clr", tmo_err, 1'b0);
    check("h_hs", cmd_valid, 1'b0);
    repeat (7) tick();
    cmd_done = 1'b1;
    tick();
    cmd_done = 1'b0;
    check("h_tmo_collide", tmo_err, 1'b0);
    check("h_idle", busy, 1'b0);

    // Asynchronous reset in ISSUE with pend=0110 (rr_ptr=1, key 3 granted).
    cmd_ready = 1'b0;
    key_pulse = 4'b1000;
    tick();
    key_pulse = '0;
    tick();
    check("i_valid", cmd_valid, 1'b1);
    check("i_code", cmd_code, 2'd3);
    key_pulse = 4'b0110;
    tick();
    key_pulse = '0;
    check("i_pend", pend, 4'b0110);
    #2;
    rst_n = 1'b0;
    #1;
    check_all("i_rst", 1'b0, 2'd0, 1'b0, 4'b0000, 1'b0, 1'b0);
    tick();
    rst_n     = 1'b1;
    cmd_ready = 1'b1;
    repeat (4) tick();
    check("i_quiet_valid", cmd_valid, 1'b0);
    check("i_quiet_busy", busy, 1'b0);
    check("i_quiet_pend", pend, 4'b0000);
    key_pulse = 4'b0100;
    tick();
    key_pulse = '0;
    serve("i_new", 2'd2, 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
